// File: rtl/regbank_exec.sv
// rtl/regbank_exec.sv - register bank with repeat-count execution unit
// Loads land in IDLE only; each instruction iterates READ/EXEC R times (R=0 runs once).
module regbank_exec #(
   parameter int WIDTH  = 16,
   parameter int NREG   = 8,
   parameter int ADDR_W = $clog2(NREG),
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  value,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic              ldV,
   input  logic              ldR,
   input  logic              ldIR,
   input  logic [ADDR_W-1:0] peek_addr,
   output logic [WIDTH-1:0]  peek_data,
   output logic [WIDTH-1:0]  display,
   output logic              busy,
   output logic              done,
   output logic              carry,
   output logic              zero,
   output logic              ill
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  regs_q [NREG];
   logic [WIDTH-1:0]  ir_q, a_q, b_q, display_q;
   logic [CNT_W-1:0]  r_q, cnt_q, eff_r;
   logic              carry_q, zero_q, ill_q;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] rd, rs1, rs2;
   logic              legal, idle, last_iter;
   logic [WIDTH-1:0]  res_d;
   logic              cout_d;
   logic              unused_ir;

   assign opcode    = ir_q[WIDTH-1 -: 4];
   assign rd        = ir_q[WIDTH-5 -: ADDR_W];
   assign rs1       = ir_q[WIDTH-5-ADDR_W -: ADDR_W];
   assign rs2       = ir_q[WIDTH-5-2*ADDR_W -: ADDR_W];
   assign unused_ir = ^ir_q;
   assign legal     = ~opcode[3];
   assign idle      = (state_q == S_IDLE);
   assign eff_r     = (r_q == '0) ? CNT_W'(1) : r_q;
   // Illegal opcodes never repeat, regardless of R.
   assign last_iter = !legal || (cnt_q == eff_r - CNT_W'(1));

   always_comb begin
      res_d  = '0;
      cout_d = 1'b0;
      case (opcode[2:0])
         3'd0: {cout_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
         3'd1: begin
            res_d  = a_q - b_q;
            cout_d = (a_q < b_q);
         end
         3'd2: res_d = a_q & b_q;
         3'd3: res_d = a_q | b_q;
         3'd4: res_d = a_q ^ b_q;
         3'd5: res_d = {a_q[WIDTH-2:0], 1'b0};
         3'd6: res_d = {1'b0, a_q[WIDTH-1:1]};
         default: res_d = a_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (ldIR) state_d = S_READ;
         S_READ: state_d = S_EXEC;
         S_EXEC: state_d = last_iter ? S_DONE : S_READ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         display_q <= '0;
         r_q       <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         ill_q     <= 1'b0;
      end else begin
         if (idle) begin
            if (ldV) regs_q[ld_addr] <= value;
            if (ldR) r_q <= value[CNT_W-1:0];
            if (ldIR) begin
               ir_q  <= value;
               ill_q <= 1'b0;
               cnt_q <= '0;
            end
         end
         // Operands are re-read every iteration so rd==rs1 chains accumulate.
         if (state_q == S_READ) begin
            a_q <= regs_q[rs1];
            b_q <= regs_q[rs2];
         end
         if (state_q == S_EXEC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (legal) begin
               regs_q[rd] <= res_d;
               display_q  <= res_d;
               carry_q    <= cout_d;
               zero_q     <= (res_d == '0);
            end else begin
               ill_q <= 1'b1;
            end
         end
      end
   end

   assign peek_data = regs_q[peek_addr];
   assign display   = display_q;
   assign busy      = (state_q == S_READ) || (state_q == S_EXEC);
   assign done      = (state_q == S_DONE);
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign ill       = ill_q;

endmodule

// File: tb/tb_regbank_exec.sv
// tb/tb_regbank_exec.sv - directed self-checking bench for regbank_exec
// Inputs change and outputs are sampled on the falling edge.
module tb_regbank_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic [2:0]  ld_addr, peek_addr;
   logic        ldV, ldR, ldIR;
   logic [15:0] peek_data, display;
   logic        busy, done, carry, zero, ill;

   int ntot  = 0;
   int npass = 0;
   int nb;
   int ndone;

   regbank_exec dut (
      .clk(clk), .rst(rst), .value(value), .ld_addr(ld_addr),
      .ldV(ldV), .ldR(ldR), .ldIR(ldIR), .peek_addr(peek_addr),
      .peek_data(peek_data), .display(display), .busy(busy),
      .done(done), .carry(carry), .zero(zero), .ill(ill)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_reg(input logic [2:0] a, input logic [15:0] v);
      ldV = 1'b1; ld_addr = a; value = v;
      tick();
      ldV = 1'b0;
   endtask

   task automatic load_r(input logic [15:0] v);
      ldR = 1'b1; value = v;
      tick();
      ldR = 1'b0;
   endtask

   task automatic start(input logic [15:0] ir);
      ldIR = 1'b1; value = ir;
      tick();
      ldIR = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [2:0] a, input logic [15:0] exp);
      peek_addr = a;
      #1;
      chk(tag, peek_data, exp);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_display"}, display, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_carry"}, carry, 0);
      chk({pfx, "_zero"}, zero, 0);
      chk({pfx, "_ill"}, ill, 0);
      for (int i = 0; i < 8; i++) peek($sformatf("%s_peek%0d", pfx, i), 3'(i), 16'h0);
   endtask

   initial begin
      rst = 1'b1; value = '0; ld_addr = '0; peek_addr = '0;
      ldV = 1'b0; ldR = 1'b0; ldIR = 1'b0;
      repeat (2) tick();
      chk_reset_outputs("por");
      rst = 1'b0;
      tick();

      // ADD r3,r1,r2
      load_reg(3'd1, 16'd6);
      load_reg(3'd2, 16'd1);
      start(16'h0650);
      chk("add_s1_busy", busy, 1);
      chk("add_s1_display", display, 0);
      tick();
      chk("add_s2_busy", busy, 1);
      chk("add_s2_done", done, 0);
      tick();
      chk("add_done", done, 1);
      chk("add_busy_drop", busy, 0);
      chk("add_display", display, 16'd7);
      chk("add_carry", carry, 0);
      chk("add_zero", zero, 0);
      peek("add_peek_r3", 3'd3, 16'd7);
      tick();
      chk("add_done_1cyc", done, 0);

      // SUB r3,r2,r1 with borrow
      start(16'h1688);
      repeat (2) tick();
      chk("sub_display", display, 16'hFFFB);
      chk("sub_carry", carry, 1);
      chk("sub_zero", zero, 0);
      tick();
      load_reg(3'd1, 16'd5);
      load_reg(3'd2, 16'd5);
      start(16'h1650);
      repeat (2) tick();
      chk("subz_display", display, 0);
      chk("subz_zero", zero, 1);
      chk("subz_carry", carry, 0);
      tick();

      // ldV and ldIR in the same cycle: MOV r5,r4 sees the new r4
      ldV = 1'b1; ld_addr = 3'd4; ldIR = 1'b1; value = 16'h7B00;
      tick();
      ldV = 1'b0; ldIR = 1'b0;
      repeat (2) tick();
      chk("mov_display", display, 16'h7B00);
      peek("mov_peek_r5", 3'd5, 16'h7B00);
      tick();

      // Repeat ADD r0,r0,r1 three times with lockout pulse while busy
      load_reg(3'd0, 16'd0);
      load_reg(3'd1, 16'd4);
      load_r(16'd3);
      start(16'h0008);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("rep_busy_s%0d", i + 1), busy, (i < 6) ? 1 : 0);
         chk($sformatf("rep_done_s%0d", i + 1), done, (i == 6) ? 1 : 0);
         chk($sformatf("rep_display_s%0d", i + 1), display,
             (i < 2) ? 16'h7B00 : (i < 4) ? 16'd4 : (i < 6) ? 16'd8 : 16'd12);
         if (i == 0) begin
            ldV = 1'b1; ld_addr = 3'd1; value = 16'd99; ldR = 1'b1; ldIR = 1'b1;
         end else begin
            ldV = 1'b0; ldR = 1'b0; ldIR = 1'b0;
         end
         tick();
      end
      chk("rep_done_end", done, 0);
      peek("rep_peek_r0", 3'd0, 16'd12);
      peek("rep_peek_r1", 3'd1, 16'd4);

      // R persists: same instruction again runs three iterations
      start(16'h0008);
      nb = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (busy) nb++;
         tick();
      end
      chk("persist_done_seen", done, 1);
      chk("persist_busy_cycles", nb, 6);
      chk("persist_display", display, 16'd24);
      tick();

      // R=0 runs once
      load_r(16'd0);
      start(16'h0008);
      tick();
      chk("r0_busy", busy, 1);
      tick();
      chk("r0_done", done, 1);
      chk("r0_display", display, 16'd28);
      tick();

      // Illegal opcode
      start(16'hF000);
      chk("ill_s1_busy", busy, 1);
      repeat (2) tick();
      chk("ill_done", done, 1);
      chk("ill_flag", ill, 1);
      chk("ill_display", display, 16'd28);
      peek("ill_peek_r0", 3'd0, 16'd28);
      tick();
      chk("ill_sticky", ill, 1);
      chk("ill_no_repeat", done, 0);
      start(16'h7C40);
      chk("ill_cleared", ill, 0);
      repeat (2) tick();
      chk("mov6_display", display, 16'd4);
      tick();

      // Mid-operation reset at the second EXEC
      load_r(16'd5);
      start(16'h0008);
      repeat (2) tick();
      chk("rst_first_result", display, 16'd32);
      tick();
      chk("rst_second_exec_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      tick();
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) ndone++;
         tick();
      end
      chk("midrst_no_done", ndone, 0);
      chk("midrst_display", display, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/regbank_exec.md
# regbank_exec

Parametrised register bank with a multi-cycle execution unit, successor to the fixed two-operand load/ADD/SUB datapath. Operands are written into an NREG-entry register file, an instruction word selects opcode and register addresses, and a repeat counter re-executes the instruction up to 2^CNT_W−1 times, so iterated ADD gives multiply. Sits between the `value` load bus and the `display` output, in the same position as the previous top-level datapath.

## Interface
- WIDTH, 16: datapath and register width; must be ≥ 4+3·ADDR_W.
- NREG, 8: number of registers; power of two, ≥ 2.
- ADDR_W, $clog2(NREG): register address width (derived).
- CNT_W, 8: repeat-counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- value  in  WIDTH  shared load bus for data, instruction and repeat count.
- ld_addr  in  ADDR_W  target register for ldV.
- ldV  in  1  write `value` into reg[ld_addr].
- ldR  in  1  load repeat count R ← value[CNT_W-1:0].
- ldIR  in  1  load instruction ← value and start execution.
- peek_addr  in  ADDR_W  combinational read address.
- peek_data  out  WIDTH  reg[peek_addr], combinational.
- display  out  WIDTH  last written result.
- busy  out  1  execution in progress.
- done  out  1  one-cycle pulse after the final iteration.
- carry  out  1  ADD carry-out / SUB borrow of the last write.
- zero  out  1  last result == 0.
- ill  out  1  sticky illegal-opcode flag; cleared by the next accepted ldIR.

## Operation
- Instruction fields, MSB down: opcode[WIDTH-1:WIDTH-4], rd, rs1, rs2 (ADDR_W bits each); remaining LSBs ignored.
- Opcodes: 0 ADD, 1 SUB (rs1−rs2), 2 AND, 3 OR, 4 XOR, 5 SHL rs1 by 1, 6 SHR rs1 by 1 (logical), 7 MOV rd←rs1; 8–15 illegal.
- Arithmetic is modulo 2^WIDTH, unsigned. carry = carry-out (ADD), 1 if rs1<rs2 (SUB), otherwise 0. zero = (result==0).
- FSM: IDLE → READ (latch reg[rs1], reg[rs2]) → EXEC (compute; write rd, display, carry, zero) → READ while iterations remain, else DONE → IDLE.
- Iteration count = R, with R=0 treated as 1. R is not modified by execution and persists across instructions.
- Each iteration re-reads the registers, so rd=rs1 chains (e.g. ADD r0,r0,r1) accumulate.
- Illegal opcode: ill←1 and no register, display or flag write; the FSM still passes through a single READ/EXEC/DONE with no repeats.
- ldV, ldR and ldIR are accepted only in IDLE and ignored while busy=1.
- Several loads asserted in the same IDLE cycle all take effect at that edge. The instruction starts the next cycle and sees the newly written register and R.
- Reset values: every register 0, R=0, instruction 0, display=0, busy=0, done=0, carry=0, zero=0, ill=0, state IDLE.

## Timing
- Edge k samples ldIR=1 in IDLE: busy=1 from k+1; first READ at cycle k+1, EXEC at k+2.
- Each iteration takes 2 cycles. Result n is written on the EXEC edge at cycle k+2n, and display changes at that edge.
- done=1 for exactly one cycle (state DONE, cycle k+2N+1); busy drops in the same cycle done rises. Total latency from ldIR to done = 2N+1 cycles.
- ldIR is accepted again in the cycle after done.
- peek_data has zero latency and shows a write from the cycle after its edge.
- rst asserted at any time, including mid-iteration: all outputs go to reset values immediately (asynchronously), the partial result is discarded and the FSM returns to IDLE. Release is synchronous to the next clk edge.

## Test plan
- Reset: assert rst mid-simulation → display=0, busy=0, done=0, carry=0, zero=0, ill=0, and peek_data=0 for every address.
- ADD: r1=6, r2=1, ldIR 0x0650 (ADD r3,r1,r2) → display=7 at cycle k+2, done at k+3, carry=0, zero=0, peek r3=7.
- SUB borrow: r1=6, r2=1, ldIR 0x1688 (SUB r3,r2,r1) → display=0xFFFB, carry=1; then r1=r2=5, ldIR 0x1650 → display=0, zero=1, carry=0.
- Repeat: r0=0, r1=4, R=3, ldIR 0x0008 (ADD r0,r0,r1) → display sequence 4, 8, 12; busy high 6 cycles; single done pulse; peek r0=12. With R=0 → single iteration.
- Busy lockout: during the repeat test, pulse ldV(r1=99), ldR and ldIR → all ignored, final r0=12, r1=4.
- Illegal op / mid-op reset: ldIR 0xF000 → ill=1, display unchanged, done after 3 cycles. Start a repeat with R=5 and assert rst at the second EXEC → all reset values, no done pulse.
